// File: rtl/pc_seq_pkg.sv
//------------------------------------------------------------------------------
// Module   : pc_seq_pkg
// Brief    : Shared types and constants for the next-PC sequencer.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package pc_seq_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_e;

    localparam int          PC_INC       = 4;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam int          FLUSH_CNT_W  = 2;

endpackage

`default_nettype wire

// File: rtl/mux_2x1.sv
//------------------------------------------------------------------------------
// Module   : mux_2x1
// Brief    : Parameterised 2:1 multiplexer (selectLine=1 picks muxIn1_i).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mux_2x1 #(
    parameter int regSize = 32
) (
    input  logic [regSize-1:0] muxIn0_i,
    input  logic [regSize-1:0] muxIn1_i,
    input  logic               selectLine,
    output logic [regSize-1:0] muxOut_o
);

    assign muxOut_o = selectLine ? muxIn1_i : muxIn0_i;

endmodule

`default_nettype wire

// File: rtl/pc_seq_ctrl.sv
//------------------------------------------------------------------------------
// Module   : pc_seq_ctrl
// Brief    : Next-PC sequencer: PC register, redirect/stall/flush control.
//            Optional perf counters enabled by macro PC_SEQ_PERF_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pc_seq_ctrl
    import pc_seq_pkg::*;
#(
    parameter int                 regSize      = 32,
    parameter logic [regSize-1:0] RESET_PC     = regSize'(RESET_PC_DEF),
    parameter int                 FLUSH_CYCLES = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               branchTaken,
    input  logic [regSize-1:0] branchTarget,
    input  logic               hazardStall,
    output logic [regSize-1:0] pc_out,
    output logic [regSize-1:0] nextPC,
    output logic               pcSelect,
    output logic               pcWrite,
    output logic               ifIdWrite,
    output logic               ifIdFlush,
`ifdef PC_SEQ_PERF_EN
    output logic [31:0]        redirectCount,
    output logic [31:0]        stallCount,
`endif
    output logic               idExFlush
);

    localparam logic [FLUSH_CNT_W-1:0] FLUSH_RELOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);
    localparam state_e                 REDIR_STATE  = (FLUSH_CYCLES == 1) ? RUN : FLUSH;

    state_e                   state_q, state_d;
    logic [FLUSH_CNT_W-1:0]   cnt_q, cnt_d;
    logic [regSize-1:0]       pc_q;
    logic [regSize-1:0]       w_pc_inc;
    logic [regSize-1:0]       w_target;
    logic                     w_tgt_unused;

    assign w_pc_inc     = pc_q + regSize'(PC_INC);
    assign w_target     = {branchTarget[regSize-1:2], 2'b00};
    assign w_tgt_unused = ^branchTarget[1:0];
    assign pc_out       = pc_q;

    mux_2x1 #(
        .regSize(regSize)
    ) u_next_pc_mux (
        .muxIn0_i  (w_pc_inc),
        .muxIn1_i  (w_target),
        .selectLine(pcSelect),
        .muxOut_o  (nextPC)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            cnt_q   <= '0;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (pcWrite) begin
                pc_q <= nextPC;
            end
        end
    end

    // A redirect wins in every state, so it is decoded ahead of the state case.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (branchTaken) begin
            state_d = REDIR_STATE;
            cnt_d   = FLUSH_RELOAD;
        end else begin
            case (state_q)
                RUN, STALL: begin
                    state_d = hazardStall ? STALL : RUN;
                end
                FLUSH: begin
                    if (cnt_q <= FLUSH_CNT_W'(1)) begin
                        state_d = RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_q - FLUSH_CNT_W'(1);
                    end
                end
                default: begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        pcSelect  = 1'b0;
        pcWrite   = 1'b1;
        ifIdWrite = 1'b1;
        ifIdFlush = 1'b0;
        idExFlush = 1'b0;
        if (branchTaken) begin
            pcSelect  = 1'b1;
            ifIdFlush = 1'b1;
            idExFlush = 1'b1;
        end else begin
            case (state_q)
                RUN, STALL: begin
                    if (hazardStall) begin
                        pcWrite   = 1'b0;
                        ifIdWrite = 1'b0;
                        idExFlush = 1'b1;
                    end
                end
                FLUSH: begin
                    ifIdFlush = 1'b1;
                end
                default: begin
                    pcWrite = 1'b1;
                end
            endcase
        end
    end

`ifdef PC_SEQ_PERF_EN
    logic [31:0] redir_cnt_q;
    logic [31:0] stall_cnt_q;

    // Both counters saturate rather than wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            redir_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (branchTaken && (redir_cnt_q != 32'hFFFF_FFFF)) begin
                redir_cnt_q <= redir_cnt_q + 32'd1;
            end
            if (!pcWrite && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign redirectCount = redir_cnt_q;
    assign stallCount    = stall_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pc_seq_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_pc_seq_ctrl
// Brief    : Directed self-checking bench for pc_seq_ctrl (two configurations).
//            Exercises perf counters when PC_SEQ_PERF_EN is defined.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_pc_seq_ctrl;

    logic        clk = 1'b0;
    int          vec  = 0;
    int          miss = 0;

    // Instance A: RESET_PC=0x100, FLUSH_CYCLES=1
    logic        ra, bta, hza;
    logic [31:0] tga;
    logic [31:0] pca, npa;
    logic        sela, pwa, iwa, ifa, iea;
    // Instance B: RESET_PC=0, FLUSH_CYCLES=3
    logic        rb, btb, hzb;
    logic [31:0] tgb;
    logic [31:0] pcb, npb;
    logic        selb, pwb, iwb, ifb, ieb;
`ifdef PC_SEQ_PERF_EN
    logic [31:0] rca, sca, rcb, scb;
`endif

    always #5 clk = ~clk;

    pc_seq_ctrl #(.regSize(32), .RESET_PC(32'h100), .FLUSH_CYCLES(1)) dut_a (
        .clk(clk), .reset(ra), .branchTaken(bta), .branchTarget(tga),
        .hazardStall(hza), .pc_out(pca), .nextPC(npa), .pcSelect(sela),
        .pcWrite(pwa), .ifIdWrite(iwa), .ifIdFlush(ifa),
`ifdef PC_SEQ_PERF_EN
        .redirectCount(rca), .stallCount(sca),
`endif
        .idExFlush(iea)
    );

    pc_seq_ctrl #(.regSize(32), .RESET_PC(32'h0), .FLUSH_CYCLES(3)) dut_b (
        .clk(clk), .reset(rb), .branchTaken(btb), .branchTarget(tgb),
        .hazardStall(hzb), .pc_out(pcb), .nextPC(npb), .pcSelect(selb),
        .pcWrite(pwb), .ifIdWrite(iwb), .ifIdFlush(ifb),
`ifdef PC_SEQ_PERF_EN
        .redirectCount(rcb), .stallCount(scb),
`endif
        .idExFlush(ieb)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        ra = 1'b1; bta = 1'b0; hza = 1'b0; tga = '0;
        rb = 1'b1; btb = 1'b0; hzb = 1'b0; tgb = '0;
        tick();
        chk("A reset pc", pca, 32'h100);
        chk("A reset nextPC", npa, 32'h104);
        chk("A reset pcSelect", {31'd0, sela}, 32'd0);
        chk("A reset pcWrite", {31'd0, pwa}, 32'd1);
        chk("A reset ifIdWrite", {31'd0, iwa}, 32'd1);
        chk("A reset ifIdFlush", {31'd0, ifa}, 32'd0);
        chk("A reset idExFlush", {31'd0, iea}, 32'd0);
        chk("B reset pc", pcb, 32'h0);
        ra = 1'b0; rb = 1'b0;

        tick(); chk("A run pc1", pca, 32'h104);
        tick(); chk("A run pc2", pca, 32'h108);
        tick(); chk("A run pc3", pca, 32'h10C);
        chk("A run ifIdFlush", {31'd0, ifa}, 32'd0);

        // Redirect to 0x10, then branch to 0x2003 (low bits dropped)
        bta = 1'b1; tga = 32'h10; tick(); bta = 1'b0; #1;
        chk("A pc 0x10", pca, 32'h10);
        bta = 1'b1; tga = 32'h2003; #1;
        chk("A br pcSelect", {31'd0, sela}, 32'd1);
        chk("A br nextPC", npa, 32'h2000);
        chk("A br ifIdFlush", {31'd0, ifa}, 32'd1);
        chk("A br idExFlush", {31'd0, iea}, 32'd1);
        tick(); bta = 1'b0; #1;
        chk("A br pc", pca, 32'h2000);
        chk("A post-br ifIdFlush", {31'd0, ifa}, 32'd0);
        chk("A post-br pcSelect", {31'd0, sela}, 32'd0);

        // Load-use stall for two cycles at 0x40
        bta = 1'b1; tga = 32'h40; tick(); bta = 1'b0; hza = 1'b1; #1;
        chk("A stall pc0", pca, 32'h40);
        chk("A stall pcWrite", {31'd0, pwa}, 32'd0);
        chk("A stall ifIdWrite", {31'd0, iwa}, 32'd0);
        chk("A stall idExFlush", {31'd0, iea}, 32'd1);
        chk("A stall ifIdFlush", {31'd0, ifa}, 32'd0);
        tick();
        chk("A stall pc1", pca, 32'h40);
        chk("A stall2 pcWrite", {31'd0, pwa}, 32'd0);
        tick();
        chk("A stall pc2", pca, 32'h40);
        hza = 1'b0; #1;
        chk("A resume pcWrite", {31'd0, pwa}, 32'd1);
        chk("A resume ifIdWrite", {31'd0, iwa}, 32'd1);
        chk("A resume idExFlush", {31'd0, iea}, 32'd0);
        tick();
        chk("A resume pc", pca, 32'h44);

        // Branch and stall together: branch wins
        hza = 1'b1; bta = 1'b1; tga = 32'h80; #1;
        chk("A both pcSelect", {31'd0, sela}, 32'd1);
        chk("A both pcWrite", {31'd0, pwa}, 32'd1);
        tick(); hza = 1'b0; bta = 1'b0; #1;
        chk("A both pc", pca, 32'h80);
        chk("A both no stall", {31'd0, pwa}, 32'd1);
        tick();
        chk("A both pc+4", pca, 32'h84);

        // PC wrap at top of address space
        bta = 1'b1; tga = 32'hFFFF_FFFE; #1;
        chk("A wrap target", npa, 32'hFFFF_FFFC);
        tick(); bta = 1'b0; #1;
        chk("A wrap pc", pca, 32'hFFFF_FFFC);
        chk("A wrap nextPC", npa, 32'h0);
        tick();
        chk("A wrapped pc", pca, 32'h0);

`ifdef PC_SEQ_PERF_EN
        chk("A redirectCount", rca, 32'd5);
        chk("A stallCount", sca, 32'd2);
        ra = 1'b1; tick(); ra = 1'b0; #1;
        chk("A perf reset redir", rca, 32'd0);
        chk("A perf reset stall", sca, 32'd0);
        bta = 1'b1; tga = 32'h500; tick(); tick(); bta = 1'b0;
        hza = 1'b1; tick(); tick(); tick(); hza = 1'b0; #1;
        chk("A perf redir 2", rca, 32'd2);
        chk("A perf stall 3", sca, 32'd3);
`endif

        // Instance B: three-cycle flush with re-redirect in 2nd flush cycle
        btb = 1'b1; tgb = 32'h200; #1;
        chk("B br ifIdFlush", {31'd0, ifb}, 32'd1);
        chk("B br idExFlush", {31'd0, ieb}, 32'd1);
        tick(); btb = 1'b0; hzb = 1'b1; #1;
        chk("B fl1 pc", pcb, 32'h200);
        chk("B fl1 ifIdFlush", {31'd0, ifb}, 32'd1);
        chk("B fl1 idExFlush", {31'd0, ieb}, 32'd0);
        chk("B fl1 pcSelect", {31'd0, selb}, 32'd0);
        chk("B fl1 stall ignored", {31'd0, pwb}, 32'd1);
        tick();
        chk("B fl2 pc", pcb, 32'h204);
        btb = 1'b1; tgb = 32'h300; hzb = 1'b0; #1;
        chk("B rebr pcSelect", {31'd0, selb}, 32'd1);
        chk("B rebr nextPC", npb, 32'h300);
        chk("B rebr idExFlush", {31'd0, ieb}, 32'd1);
        tick(); btb = 1'b0; #1;
        chk("B rebr pc", pcb, 32'h300);
        chk("B rebr fl1", {31'd0, ifb}, 32'd1);
        tick();
        chk("B rebr pc+4", pcb, 32'h304);
        chk("B rebr fl2", {31'd0, ifb}, 32'd1);
        tick();
        chk("B run pc", pcb, 32'h308);
        chk("B run ifIdFlush", {31'd0, ifb}, 32'd0);

        // Reset in the middle of a flush
        btb = 1'b1; tgb = 32'h500; tick(); btb = 1'b0; #1;
        chk("B mid pc", pcb, 32'h500);
        chk("B mid ifIdFlush", {31'd0, ifb}, 32'd1);
        rb = 1'b1; tick(); rb = 1'b0; #1;
        chk("B rst pc", pcb, 32'h0);
        chk("B rst ifIdFlush", {31'd0, ifb}, 32'd0);
        chk("B rst idExFlush", {31'd0, ieb}, 32'd0);
        chk("B rst pcSelect", {31'd0, selb}, 32'd0);
        tick();
        chk("B rst run pc", pcb, 32'h4);
        chk("B rst run ifIdFlush", {31'd0, ifb}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule

`default_nettype wire
